// File: rtl/fetch_rr_arbiter.sv
// Round-robin arbiter sharing one in-order req/gnt/rvalid fetch port among N_PORTS requesters.
// A waiting request is locked until granted; an ID FIFO steers each response back to its issuer.
module fetch_rr_arbiter #(
  parameter int N_PORTS          = 4,
  parameter int FETCH_ADDR_WIDTH = 32,
  parameter int FETCH_DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_PORTS-1:0]                    req_i,
  input  logic [N_PORTS*FETCH_ADDR_WIDTH-1:0]   addr_i,
  output logic [N_PORTS-1:0]                    gnt_o,
  output logic [N_PORTS-1:0]                    rvalid_o,
  output logic [FETCH_DATA_WIDTH-1:0]           rdata_o,
  output logic                                  fetch_req_o,
  output logic [FETCH_ADDR_WIDTH-1:0]           fetch_addr_o,
  input  logic                                  fetch_gnt_i,
  input  logic                                  fetch_rvalid_i,
  input  logic [FETCH_DATA_WIDTH-1:0]           fetch_rdata_i,
  output logic                                  err_o
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PORTS - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0] lockIdx_q, lockIdx_d;
  logic [IDX_W-1:0] idFifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] outCnt_q, outCnt_d;
  logic             err_q;

  logic [IDX_W-1:0] arbSel;
  logic [IDX_W-1:0] sel;
  logic             handshake;
  logic             pop;

  function automatic logic [IDX_W-1:0] wrapIdx(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N_PORTS) sum = sum - N_PORTS;
    return IDX_W'(sum);
  endfunction

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // Scan downward so the last hit is the first requester at or after rrPtr_q.
  always_comb begin
    arbSel = rrPtr_q;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req_i[wrapIdx(rrPtr_q, i)]) arbSel = wrapIdx(rrPtr_q, i);
    end
  end

  assign sel         = (state_q == LOCKED) ? lockIdx_q : arbSel;
  assign fetch_req_o = ((state_q == ARB) ? |req_i : 1'b1) & (outCnt_q < MAX_CNT);
  assign handshake   = fetch_req_o & fetch_gnt_i;
  assign pop         = fetch_rvalid_i & (outCnt_q != '0);

  assign fetch_addr_o = fetch_req_o ? addr_i[int'(sel)*FETCH_ADDR_WIDTH +: FETCH_ADDR_WIDTH] : '0;
  assign rdata_o      = pop ? fetch_rdata_i : '0;
  assign err_o        = err_q;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (handshake) gnt_o[sel] = 1'b1;
    if (pop) rvalid_o[idFifo_q[rdPtr_q]] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    lockIdx_d = lockIdx_q;
    rrPtr_d   = rrPtr_q;
    if (handshake) begin
      state_d = ARB;
      rrPtr_d = (sel == LAST_IDX) ? '0 : sel + 1'b1;
    end else if ((state_q == ARB) && fetch_req_o) begin
      state_d   = LOCKED;
      lockIdx_d = sel;
    end
  end

  always_comb begin
    outCnt_d = outCnt_q;
    if (handshake && !pop) outCnt_d = outCnt_q + 1'b1;
    else if (!handshake && pop) outCnt_d = outCnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      rrPtr_q   <= '0;
      lockIdx_q <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      outCnt_q  <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) idFifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      lockIdx_q <= lockIdx_d;
      outCnt_q  <= outCnt_d;
      if (handshake) begin
        idFifo_q[wrPtr_q] <= sel;
        wrPtr_q           <= nextPtr(wrPtr_q);
      end
      if (pop) rdPtr_q <= nextPtr(rdPtr_q);
      // A response with nothing outstanding has no owner and is flagged until reset.
      if (fetch_rvalid_i && (outCnt_q == '0)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_rr_arbiter.sv
// Bench for fetch_rr_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model, on MAX_OUTSTANDING=2 and =4 instances.
module tb_fetch_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [N-1:0]  req;
    logic          gnt;
    logic          rv;
    logic [DW-1:0] rdata;
    logic [N-1:0]  eGnt;
    logic [N-1:0]  eRv;
    logic [DW-1:0] eRdata;
    logic          eReq;
    logic [AW-1:0] eAddr;
    logic          eErr;
  } vec_t;

  logic clk;
  logic rst_n;

  logic [N-1:0]    reqI    [2];
  logic [N*AW-1:0] addrI   [2];
  logic            fGntI   [2];
  logic            fRvI    [2];
  logic [DW-1:0]   fRdataI [2];
  logic [N-1:0]    gntO    [2];
  logic [N-1:0]    rvO     [2];
  logic [DW-1:0]   rdataO  [2];
  logic            fReqO   [2];
  logic [AW-1:0]   fAddrO  [2];
  logic            errO    [2];

  int checks;
  int errors;

  int           mMax    [2];
  int           mRr     [2];
  bit           mLocked [2];
  int           mLock   [2];
  int           mCnt    [2];
  int           mFifo   [2][8];
  bit           mErr    [2];
  logic [N-1:0] lastGnt [2];

  vec_t vecs [22];

  fetch_rr_arbiter #(.N_PORTS(N), .FETCH_ADDR_WIDTH(AW), .FETCH_DATA_WIDTH(DW), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(reqI[0]), .addr_i(addrI[0]), .gnt_o(gntO[0]),
    .rvalid_o(rvO[0]), .rdata_o(rdataO[0]), .fetch_req_o(fReqO[0]), .fetch_addr_o(fAddrO[0]),
    .fetch_gnt_i(fGntI[0]), .fetch_rvalid_i(fRvI[0]), .fetch_rdata_i(fRdataI[0]), .err_o(errO[0])
  );

  fetch_rr_arbiter #(.N_PORTS(N), .FETCH_ADDR_WIDTH(AW), .FETCH_DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dutM4 (
    .clk(clk), .rst_n(rst_n), .req_i(reqI[1]), .addr_i(addrI[1]), .gnt_o(gntO[1]),
    .rvalid_o(rvO[1]), .rdata_o(rdataO[1]), .fetch_req_o(fReqO[1]), .fetch_addr_o(fAddrO[1]),
    .fetch_gnt_i(fGntI[1]), .fetch_rvalid_i(fRvI[1]), .fetch_rdata_i(fRdataI[1]), .err_o(errO[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic [N-1:0] req, input logic gnt, input logic rv,
                                 input logic [DW-1:0] rdata, input logic [N-1:0] eGnt,
                                 input logic [N-1:0] eRv, input logic [DW-1:0] eRdata,
                                 input logic eReq, input logic [AW-1:0] eAddr, input logic eErr);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.eGnt = eGnt; v.eRv = eRv; v.eRdata = eRdata; v.eReq = eReq; v.eAddr = eAddr; v.eErr = eErr;
    return v;
  endfunction

  task automatic cmp(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (dut%0d): got 0x%0h, expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic modelReset(input int d);
    mRr[d] = 0; mLocked[d] = 0; mLock[d] = 0; mCnt[d] = 0; mErr[d] = 0; lastGnt[d] = '0;
  endtask

  task automatic applyStimulus(input int d, input logic [N-1:0] req, input logic gnt,
                               input logic rv, input logic [DW-1:0] rdata);
    reqI[d] = req; fGntI[d] = gnt; fRvI[d] = rv; fRdataI[d] = rdata;
  endtask

  // Compare one instance against the model for the current inputs, then advance the model by one clock.
  task automatic checkOutput(input int d);
    int            sel;
    bit            expReq;
    bit            hs;
    logic [N-1:0]  eg;
    logic [N-1:0]  er;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    sel = 0;
    if (mLocked[d]) sel = mLock[d];
    else for (int i = N - 1; i >= 0; i--) if (reqI[d][(mRr[d] + i) % N]) sel = (mRr[d] + i) % N;
    expReq = (mLocked[d] || (reqI[d] != '0)) && (mCnt[d] < mMax[d]);
    hs = expReq && fGntI[d];
    ea = expReq ? addrI[d][sel*AW +: AW] : '0;
    eg = '0;
    if (hs) eg[sel] = 1'b1;
    er = '0;
    ed = '0;
    if (fRvI[d] && mCnt[d] > 0) begin
      er[mFifo[d][0]] = 1'b1;
      ed = fRdataI[d];
    end
    cmp("gnt_o", d, 64'(gntO[d]), 64'(eg));
    cmp("rvalid_o", d, 64'(rvO[d]), 64'(er));
    cmp("rdata_o", d, 64'(rdataO[d]), 64'(ed));
    cmp("fetch_req_o", d, 64'(fReqO[d]), 64'(expReq));
    cmp("fetch_addr_o", d, 64'(fAddrO[d]), 64'(ea));
    cmp("err_o", d, 64'(errO[d]), 64'(mErr[d]));
    if (rst_n) begin
      if (fRvI[d]) begin
        if (mCnt[d] > 0) begin
          for (int i = 0; i < 7; i++) mFifo[d][i] = mFifo[d][i+1];
          mCnt[d]--;
        end else mErr[d] = 1;
      end
      if (hs) begin
        mFifo[d][mCnt[d]] = sel;
        mCnt[d]++;
        mRr[d] = (sel + 1) % N;
        mLocked[d] = 0;
      end else if (!mLocked[d] && expReq) begin
        mLocked[d] = 1;
        mLock[d] = sel;
      end
      lastGnt[d] = eg;
    end
  endtask

  task automatic endCycle();
    checkOutput(0);
    checkOutput(1);
    @(negedge clk);
  endtask

  task automatic checkVector(input int i);
    cmp($sformatf("vec%0d gnt_o", i), 0, 64'(gntO[0]), 64'(vecs[i].eGnt));
    cmp($sformatf("vec%0d rvalid_o", i), 0, 64'(rvO[0]), 64'(vecs[i].eRv));
    cmp($sformatf("vec%0d rdata_o", i), 0, 64'(rdataO[0]), 64'(vecs[i].eRdata));
    cmp($sformatf("vec%0d fetch_req_o", i), 0, 64'(fReqO[0]), 64'(vecs[i].eReq));
    cmp($sformatf("vec%0d fetch_addr_o", i), 0, 64'(fAddrO[0]), 64'(vecs[i].eAddr));
    cmp($sformatf("vec%0d err_o", i), 0, 64'(errO[0]), 64'(vecs[i].eErr));
  endtask

  task automatic randomStep(input int d);
    for (int k = 0; k < N; k++) begin
      if (!reqI[d][k] || lastGnt[d][k]) begin
        reqI[d][k] = ($urandom_range(0, 2) == 0);
        addrI[d][k*AW +: AW] = $urandom;
      end
    end
    fGntI[d] = ($urandom_range(0, 3) != 0);
    fRvI[d] = (mCnt[d] > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 63) == 0);
    fRdataI[d] = $urandom;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mMax[0] = 2;
    mMax[1] = 4;
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, '0, 1'b0, 1'b0, '0);
      for (int k = 0; k < N; k++) addrI[d][k*AW +: AW] = 32'h100 * (k + 1);
      modelReset(d);
    end

    vecs[0]  = mkVec(4'b0001, 1, 0, 32'h0,        4'b0001, 4'b0000, 32'h0,        1, 32'h100, 0);
    vecs[1]  = mkVec(4'b0000, 0, 1, 32'hDEADBEEF, 4'b0000, 4'b0001, 32'hDEADBEEF, 0, 32'h0,   0);
    vecs[2]  = mkVec(4'b0110, 0, 0, 32'h0,        4'b0000, 4'b0000, 32'h0,        1, 32'h200, 0);
    vecs[3]  = mkVec(4'b0111, 0, 0, 32'h0,        4'b0000, 4'b0000, 32'h0,        1, 32'h200, 0);
    vecs[4]  = mkVec(4'b0111, 0, 0, 32'h0,        4'b0000, 4'b0000, 32'h0,        1, 32'h200, 0);
    vecs[5]  = mkVec(4'b0111, 1, 0, 32'h0,        4'b0010, 4'b0000, 32'h0,        1, 32'h200, 0);
    vecs[6]  = mkVec(4'b0101, 1, 0, 32'h0,        4'b0100, 4'b0000, 32'h0,        1, 32'h300, 0);
    vecs[7]  = mkVec(4'b0001, 1, 0, 32'h0,        4'b0000, 4'b0000, 32'h0,        0, 32'h0,   0);
    vecs[8]  = mkVec(4'b0001, 1, 1, 32'h11111111, 4'b0000, 4'b0010, 32'h11111111, 0, 32'h0,   0);
    vecs[9]  = mkVec(4'b0001, 1, 0, 32'h0,        4'b0001, 4'b0000, 32'h0,        1, 32'h100, 0);
    vecs[10] = mkVec(4'b0000, 0, 1, 32'h22222222, 4'b0000, 4'b0100, 32'h22222222, 0, 32'h0,   0);
    vecs[11] = mkVec(4'b1000, 1, 1, 32'h33333333, 4'b1000, 4'b0001, 32'h33333333, 1, 32'h400, 0);
    vecs[12] = mkVec(4'b0000, 0, 1, 32'h44444444, 4'b0000, 4'b1000, 32'h44444444, 0, 32'h0,   0);
    vecs[13] = mkVec(4'b0011, 1, 0, 32'h0,        4'b0001, 4'b0000, 32'h0,        1, 32'h100, 0);
    vecs[14] = mkVec(4'b0010, 0, 0, 32'h0,        4'b0000, 4'b0000, 32'h0,        1, 32'h200, 0);
    vecs[15] = mkVec(4'b0011, 0, 1, 32'h55555555, 4'b0000, 4'b0001, 32'h55555555, 1, 32'h200, 0);
    vecs[16] = mkVec(4'b0011, 1, 0, 32'h0,        4'b0010, 4'b0000, 32'h0,        1, 32'h200, 0);
    vecs[17] = mkVec(4'b0001, 1, 0, 32'h0,        4'b0001, 4'b0000, 32'h0,        1, 32'h100, 0);
    vecs[18] = mkVec(4'b0000, 0, 1, 32'h66666666, 4'b0000, 4'b0010, 32'h66666666, 0, 32'h0,   0);
    vecs[19] = mkVec(4'b0000, 0, 1, 32'h77777777, 4'b0000, 4'b0001, 32'h77777777, 0, 32'h0,   0);
    vecs[20] = mkVec(4'b0000, 0, 1, 32'h88888888, 4'b0000, 4'b0000, 32'h0,        0, 32'h0,   0);
    vecs[21] = mkVec(4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 32'h0,        0, 32'h0,   1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    cmp("reset gnt_o", 0, 64'(gntO[0]), 64'h0);
    cmp("reset rvalid_o", 0, 64'(rvO[0]), 64'h0);
    cmp("reset fetch_req_o", 0, 64'(fReqO[0]), 64'h0);
    cmp("reset err_o", 0, 64'(errO[0]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 22; i++) begin
      applyStimulus(0, vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
      #1;
      checkVector(i);
      endCycle();
    end

    $display("[TB] reset clears err and drops outstanding IDs");
    applyStimulus(0, '0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    modelReset(0);
    modelReset(1);
    #1;
    cmp("err cleared by reset", 0, 64'(errO[0]), 64'h0);
    endCycle();
    rst_n = 1'b1;
    applyStimulus(0, 4'b0011, 1'b1, 1'b0, '0);
    #1;
    cmp("pre-reset grant 0", 0, 64'(gntO[0]), 64'h1);
    endCycle();
    applyStimulus(0, 4'b0010, 1'b1, 1'b0, '0);
    #1;
    cmp("pre-reset grant 1", 0, 64'(gntO[0]), 64'h2);
    endCycle();
    applyStimulus(0, '0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    modelReset(0);
    modelReset(1);
    #1;
    endCycle();
    rst_n = 1'b1;
    applyStimulus(0, '0, 1'b0, 1'b1, 32'hAAAA5555);
    #1;
    cmp("orphan rvalid_o", 0, 64'(rvO[0]), 64'h0);
    cmp("orphan err_o before edge", 0, 64'(errO[0]), 64'h0);
    endCycle();
    applyStimulus(0, '0, 1'b0, 1'b0, '0);
    #1;
    cmp("orphan err_o set", 0, 64'(errO[0]), 64'h1);
    endCycle();
    #1;
    cmp("err_o sticky", 0, 64'(errO[0]), 64'h1);
    endCycle();
    rst_n = 1'b0;
    modelReset(0);
    modelReset(1);
    #1;
    cmp("err_o cleared by rst_n", 0, 64'(errO[0]), 64'h0);
    endCycle();
    rst_n = 1'b1;

    $display("[TB] round-robin with MAX_OUTSTANDING=4");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'b1111, 1'b1, (i > 0), 32'hC0DE0000 + 32'(i));
      #1;
      cmp($sformatf("rr grant %0d", i), 1, 64'(gntO[1]), 64'(1 << (i % 4)));
      cmp($sformatf("rr rvalid %0d", i), 1, 64'(rvO[1]), (i > 0) ? 64'(1 << ((i - 1) % 4)) : 64'h0);
      endCycle();
    end

    $display("[TB] randomized traffic");
    for (int c = 0; c < 2000; c++) begin
      randomStep(0);
      randomStep(1);
      #1;
      endCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_rr_arbiter.md
Name: fetch_rr_arbiter

Overview:
- Shares one instruction-fetch port (req/gnt/rvalid protocol, in-order responses) among N_PORTS fetch requesters, such as cores or prefetch engines in front of a shared icache.
- Arbitration is round-robin.
- Address is locked while a request waits for grant.
- Outstanding transactions are tracked in an ID FIFO; each response is steered back to the requester that issued it.

Parameters:
N_PORTS, 4, number of requester ports (2..8)
FETCH_ADDR_WIDTH, 32, fetch address width
FETCH_DATA_WIDTH, 32, fetch data width
MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (1..4); sets ID FIFO depth

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
req_i  in  N_PORTS  per-port fetch request
addr_i  in  N_PORTS*FETCH_ADDR_WIDTH  per-port address, port k at bits [k*AW +: AW]
gnt_o  out  N_PORTS  per-port grant
rvalid_o  out  N_PORTS  per-port response valid, one-hot or zero
rdata_o  out  FETCH_DATA_WIDTH  response data, broadcast to all ports
fetch_req_o  out  1  downstream request
fetch_addr_o  out  FETCH_ADDR_WIDTH  downstream address
fetch_gnt_i  in  1  downstream grant
fetch_rvalid_i  in  1  downstream response valid
fetch_rdata_i  in  FETCH_DATA_WIDTH  downstream response data
err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset: rr_ptr=0; FSM=ARB; ID FIFO empty; out_cnt=0; err_o=0.
- Reset values of combinational outputs: gnt_o=0, rvalid_o=0, fetch_req_o=0.
- Reset values of data outputs: rdata_o=0, fetch_addr_o=0 (driven 0 when fetch_req_o=0).
- Reset mid-operation drops all outstanding IDs. Responses arriving afterwards set err_o.
- Requester rule: hold req_i[k] and its address until gnt_o[k].
- Selection, state ARB: sel = first k with req_i[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_PORTS.
- Selection, state LOCKED: sel = lock_idx (registered). Arbitration is not re-run.
- fetch_req_o = (ARB ? |req_i : 1) & (out_cnt < MAX_OUTSTANDING).
- fetch_addr_o = addr_i[sel]. Zero-latency path, no pipeline register.
- gnt_o[sel] = fetch_req_o & fetch_gnt_i. All other gnt_o bits are 0.
- Handshake (fetch_req_o & fetch_gnt_i):
  - push sel into ID FIFO; out_cnt++;
  - rr_ptr <= (sel+1) mod N_PORTS;
  - FSM <= ARB.
- FSM ARB -> LOCKED: fetch_req_o=1 and fetch_gnt_i=0. Capture lock_idx=sel.
- FSM LOCKED: stays until handshake, then returns to ARB.
- out_cnt==MAX_OUTSTANDING while LOCKED: fetch_req_o drops to 0, lock is retained, request re-asserts once out_cnt decreases.
- Response: on fetch_rvalid_i with FIFO non-empty:
  - rvalid_o[head]=1 in the same cycle (combinational);
  - rdata_o=fetch_rdata_i;
  - pop head; out_cnt--.
- Push and pop in the same cycle: both happen, out_cnt unchanged.
- Pop has no bypass of the full check: fetch_req_o uses the registered out_cnt.
- fetch_rvalid_i with FIFO empty: rvalid_o stays 0 and err_o <= 1. err_o clears only on reset.
- FIFO is a circular buffer:
  - pointer width = clog2(MAX_OUTSTANDING), minimum 1;
  - pointers wrap modulo MAX_OUTSTANDING;
  - out_cnt width = clog2(MAX_OUTSTANDING+1).
- Fairness: a continuously requesting port is granted within N_PORTS handshakes.
- No combinational path from fetch_gnt_i to fetch_req_o.

Test Plan:
- Single port: req_i=4'b0001, addr 0x100, gnt same cycle, rvalid next cycle with 0xDEADBEEF -> gnt_o=0001; rvalid_o=0001; rdata_o=0xDEADBEEF.
- Round-robin, MAX_OUTSTANDING=4: all four ports request continuously, gnt tied 1, rvalid 1 cycle later -> grant order 0,1,2,3,0; each rvalid_o matches the port granted the previous cycle.
- Lock: ports 1 and 2 request, fetch_gnt_i low for 3 cycles -> fetch_addr_o=addr_i[1] held stable. Port 0 asserting mid-wait does not steal. Grant goes to port 1, next arbitration picks port 2.
- Outstanding limit, MAX_OUTSTANDING=2: two grants, no rvalid -> fetch_req_o=0. rvalid arrives -> fetch_req_o=1 the next cycle. Responses route in grant order.
- Simultaneous push/pop: out_cnt=1, grant port 3 while rvalid returns port 0 in the same cycle -> rvalid_o=0001, out_cnt stays 1, next rvalid -> rvalid_o=1000.
- Errors: rvalid with FIFO empty -> err_o=1 sticky, rvalid_o=0. Reset with 2 outstanding, then rvalid -> err_o=1, and err_o clears only when rst_n=0.
